// File: rtl/midori128_round_ctrl.sv
// Round sequencer for an iterative Midori128 core: whitening load, NR full rounds, one final round,
// then a valid/ready result handshake. All outputs decode from registered state only.
module midori128_round_ctrl #(
  parameter int NR = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       dec,
  input  logic       abort,
  output logic       load_state,
  output logic       round_en,
  output logic [4:0] round_idx,
  output logic       final_rnd,
  output logic       inv,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [4:0] LAST = 5'(NR - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] rcnt_q, rcnt_d;
  logic       inv_q, inv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcnt_q  <= 5'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      inv_q   <= inv_d;
    end
  end

  // Abort outranks every other transition once an operation is in flight.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    inv_d   = inv_q;
    if (state_q == S_IDLE) begin
      if (start_valid) begin
        state_d = S_LOAD;
        rcnt_d  = 5'd0;
        inv_d   = dec;
      end
    end else if (abort) begin
      state_d = S_IDLE;
      rcnt_d  = 5'd0;
      inv_d   = 1'b0;
    end else begin
      case (state_q)
        S_LOAD:  state_d = S_ROUND;
        S_ROUND: begin
          if (rcnt_q == LAST) begin
            rcnt_d  = 5'd0;
            state_d = S_FINAL;
          end else begin
            rcnt_d = rcnt_q + 5'd1;
          end
        end
        S_FINAL: state_d = S_DONE;
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
            inv_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          rcnt_d  = 5'd0;
          inv_d   = 1'b0;
        end
      endcase
    end
  end

  // Decryption walks the round constants backwards.
  always_comb begin
    start_ready = 1'b0;
    load_state  = 1'b0;
    round_en    = 1'b0;
    round_idx   = 5'd0;
    final_rnd   = 1'b0;
    busy        = 1'b1;
    out_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      S_LOAD:  load_state = 1'b1;
      S_ROUND: begin
        round_en  = 1'b1;
        round_idx = inv_q ? (LAST - rcnt_q) : rcnt_q;
      end
      S_FINAL: begin
        round_en  = 1'b1;
        final_rnd = 1'b1;
      end
      S_DONE:  out_valid = 1'b1;
      default: begin
        start_ready = 1'b0;
        busy        = 1'b1;
      end
    endcase
  end

  assign inv = inv_q;

endmodule

// File: tb/tb_midori128_round_ctrl.sv
// Directed bench for midori128_round_ctrl: expected outputs derived from cycle numbers relative to
// each start handshake, plus a second instance built with NR=1.
module tb_midori128_round_ctrl;

  localparam int NR = 19;

  logic       clk, rst;
  logic       start_valid, dec, abort, out_ready;
  logic       start_ready, load_state, round_en, final_rnd, inv, busy, out_valid;
  logic [4:0] round_idx;

  logic       s1_start, s1_dec, s1_abort, s1_rdy;
  logic       s1_sr, s1_load, s1_ren, s1_fin, s1_inv, s1_busy, s1_ov;
  logic [4:0] s1_idx;

  int tests = 0;
  int fails = 0;

  midori128_round_ctrl #(.NR(NR)) u_dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready), .dec(dec),
    .abort(abort), .load_state(load_state), .round_en(round_en), .round_idx(round_idx),
    .final_rnd(final_rnd), .inv(inv), .busy(busy), .out_valid(out_valid), .out_ready(out_ready)
  );

  midori128_round_ctrl #(.NR(1)) u_nr1 (
    .clk(clk), .rst(rst), .start_valid(s1_start), .start_ready(s1_sr), .dec(s1_dec),
    .abort(s1_abort), .load_state(s1_load), .round_en(s1_ren), .round_idx(s1_idx),
    .final_rnd(s1_fin), .inv(s1_inv), .busy(s1_busy), .out_valid(s1_ov), .out_ready(s1_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int c);
    chk({tag, ".start_ready"}, c, 32'(start_ready), 32'd1);
    chk({tag, ".busy"},        c, 32'(busy),        32'd0);
    chk({tag, ".load_state"},  c, 32'(load_state),  32'd0);
    chk({tag, ".round_en"},    c, 32'(round_en),    32'd0);
    chk({tag, ".round_idx"},   c, 32'(round_idx),   32'd0);
    chk({tag, ".final_rnd"},   c, 32'(final_rnd),   32'd0);
    chk({tag, ".inv"},         c, 32'(inv),         32'd0);
    chk({tag, ".out_valid"},   c, 32'(out_valid),   32'd0);
  endtask

  // Called in cycle 0 of an operation; the handshake completes at the next edge.
  // rel: cycle in which out_ready rises; ab: cycle in which abort rises (0 = none).
  task automatic run(input bit d, input bit tog, input int rel, input bit hold_rdy,
                     input bit hold_start, input int ab);
    int  e;
    int  idx_e;
    bit  act;
    e = (ab != 0) ? ab : rel;
    start_valid = 1'b1;
    dec         = d;
    out_ready   = hold_rdy;
    for (int c = 1; c <= e + 1; c++) begin
      step();
      act   = (c <= e);
      idx_e = (act && c >= 2 && c <= NR + 1) ? (d ? NR + 1 - c : c - 2) : 0;
      chk("load_state",  c, 32'(load_state),  32'(act && c == 1));
      chk("round_en",    c, 32'(round_en),    32'(act && c >= 2 && c <= NR + 2));
      chk("round_idx",   c, 32'(round_idx),   32'(idx_e));
      chk("final_rnd",   c, 32'(final_rnd),   32'(act && c == NR + 2));
      chk("inv",         c, 32'(inv),         32'(act && d));
      chk("busy",        c, 32'(busy),        32'(act));
      chk("start_ready", c, 32'(start_ready), 32'(!act));
      chk("out_valid",   c, 32'(out_valid),   32'(act && c >= NR + 3));
      start_valid = hold_start && act;
      if (tog) dec = ~dec;
      out_ready = hold_rdy || (c == rel);
      abort     = (c == ab);
    end
    start_valid = 1'b0;
    abort       = 1'b0;
    out_ready   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0; dec = 1'b0; abort = 1'b0; out_ready = 1'b0;
    s1_start = 1'b0; s1_dec = 1'b0; s1_abort = 1'b0; s1_rdy = 1'b0;
    #2;
    chk_idle("reset", 0);
    chk("reset.nr1_sr", 0, 32'(s1_sr), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Encrypt, result held until cycle 26
    run(1'b0, 1'b0, 26, 1'b0, 1'b0, 0);
    step();
    // Decrypt with dec toggling; abort in IDLE must not block the start
    abort = 1'b1;
    run(1'b1, 1'b1, 22, 1'b0, 1'b0, 0);
    step();
    // Back-to-back with out_ready held: second start lands in cycle 23
    run(1'b0, 1'b0, 22, 1'b1, 1'b0, 0);
    run(1'b0, 1'b0, 22, 1'b1, 1'b0, 0);
    step();
    // Abort mid-round, then confirm no result ever appears
    run(1'b0, 1'b0, 26, 1'b0, 1'b0, 10);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("post_abort.out_valid", 12 + k, 32'(out_valid), 32'd0);
      chk("post_abort.busy",      12 + k, 32'(busy),      32'd0);
    end
    // Abort and out_ready together in DONE
    run(1'b1, 1'b0, 22, 1'b0, 1'b0, 22);
    step();
    // start_valid held high throughout must not relaunch early
    run(1'b0, 1'b0, 22, 1'b1, 1'b1, 0);
    step();
    chk_idle("start_dropped", 24);

    // Asynchronous reset mid-cycle 8
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    repeat (7) step();
    chk("pre_rst.round_en", 8, 32'(round_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst", 8);
    #1;
    rst = 1'b0;
    run(1'b0, 1'b0, 22, 1'b1, 1'b0, 0);

    // NR=1 instance
    s1_start = 1'b1;
    step();
    s1_start = 1'b0;
    chk("nr1.load",      1, 32'(s1_load), 32'd1);
    chk("nr1.ren_c1",    1, 32'(s1_ren),  32'd0);
    step();
    chk("nr1.ren_c2",    2, 32'(s1_ren),  32'd1);
    chk("nr1.idx_c2",    2, 32'(s1_idx),  32'd0);
    chk("nr1.fin_c2",    2, 32'(s1_fin),  32'd0);
    step();
    chk("nr1.ren_c3",    3, 32'(s1_ren),  32'd1);
    chk("nr1.fin_c3",    3, 32'(s1_fin),  32'd1);
    chk("nr1.ov_c3",     3, 32'(s1_ov),   32'd0);
    step();
    chk("nr1.ov_c4",     4, 32'(s1_ov),   32'd1);
    chk("nr1.ren_c4",    4, 32'(s1_ren),  32'd0);
    step();
    chk("nr1.ov_c5",     5, 32'(s1_ov),   32'd1);
    s1_rdy = 1'b1;
    step();
    s1_rdy = 1'b0;
    chk("nr1.ov_c6",     6, 32'(s1_ov),   32'd0);
    chk("nr1.sr_c6",     6, 32'(s1_sr),   32'd1);
    chk("nr1.busy_c6",   6, 32'(s1_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/midori128_round_ctrl.md
# midori128_round_ctrl

Iterative sequencer for the Midori128 round datapath: SubCell, ShuffleCells/InvShuffleCells, MixColumn and KeyAdd. It accepts a start request, drives the state-register load, round-enable, round-constant index, final-round select and inverse-mode select for NR full rounds plus one final round. It then holds a result-valid handshake until the consumer accepts. It sits between the core's host interface and the combinational round logic, and contains no datapath of its own.

## Interface
- NR, default 19: number of full rounds; legal range 1..31.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start_valid  in  1  host requests a new block operation.
- start_ready  out  1  controller idle and able to accept a start.
- dec  in  1  mode, sampled only on the start handshake: 1 = decrypt, 0 = encrypt.
- abort  in  1  synchronous cancel of an in-flight operation.
- load_state  out  1  state register captures input XOR whitening key.
- round_en  out  1  state register captures round-logic output.
- round_idx  out  5  round-constant index for KeyAdd.
- final_rnd  out  1  selects the final-round path (SubCell plus whitening only).
- inv  out  1  registered mode; selects InvShuffleCells and other inverse layers.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  state register holds the finished result.
- out_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE. Registers are the state, a 5-bit round counter rcnt and the inv flag.
- **IDLE**
  - Outputs: start_ready=1, all other outputs 0.
  - On start_valid=1 at the edge: inv<=dec, rcnt<=0, go to LOAD.
- **LOAD** (1 cycle)
  - Outputs: load_state=1, round_idx=0.
  - Next state: ROUND.
- **ROUND** (NR cycles)
  - Outputs: round_en=1. round_idx=rcnt when inv=0, NR-1-rcnt when inv=1.
  - Each edge: rcnt<=rcnt+1. When rcnt==NR-1, set rcnt<=0 and go to FINAL.
- **FINAL** (1 cycle)
  - Outputs: round_en=1, final_rnd=1, round_idx=0.
  - Next state: DONE.
- **DONE**
  - Outputs: out_valid=1.
  - On out_ready=1 at the edge, go to IDLE. Otherwise hold, with out_valid stable.
- Output rules:
  - All outputs decode from registered state, rcnt and inv. No input-to-output combinational path.
  - round_idx=0 outside ROUND.
  - inv holds its latched value from LOAD through DONE and is cleared on return to IDLE.
- abort:
  - abort=1 at an edge in LOAD, ROUND, FINAL or DONE sends the FSM to IDLE, clears rcnt and inv, and suppresses any out_valid.
  - In DONE, abort takes priority over out_ready.
  - abort in IDLE is ignored and does not block a simultaneous start.
- start_valid outside IDLE is ignored. dec changes after the handshake are ignored.

## Timing
- Reset values (applied immediately on rst=1, without a clock edge):
  - state=IDLE, rcnt=0, inv=0.
  - start_ready=1, busy=0.
  - load_state, round_en, final_rnd, out_valid = 0; round_idx=0.
- Cycle numbering: the start handshake completes in cycle 0.
  - Cycle 1: LOAD.
  - Cycles 2..NR+1: ROUND.
  - Cycle NR+2: FINAL.
  - Cycle NR+3 onward: DONE.
- Latency: out_valid first high in cycle NR+3, which is cycle 22 for NR=19.
- Throughput: when out_ready is held high, out_valid lasts exactly 1 cycle. IDLE follows, so the next start is accepted at the earliest in cycle NR+4, giving one block per NR+4 cycles.
- round_en is high for exactly NR+1 consecutive cycles. load_state is high for exactly 1 cycle per operation.

## Test plan
- **Encrypt, NR=19:** start with dec=0 in cycle 0; hold out_ready=0 until cycle 26.
  - load_state=1 only in cycle 1.
  - round_en=1 in cycles 2..21, with round_idx=0,1,…,18 in cycles 2..20.
  - final_rnd=1 only in cycle 21.
  - out_valid=1 in cycles 22..26; IDLE with start_ready=1 in cycle 27.
- **Decrypt, NR=19:** start with dec=1, then toggle dec every cycle.
  - inv=1 in cycles 1..22.
  - round_idx=18,17,…,0 in cycles 2..20.
  - Timing identical to the encrypt case.
- **Back-to-back:** out_ready held at 1.
  - out_valid high only in cycle 22; start_ready=1 in cycle 23.
  - A new start in cycle 23 puts the FSM in LOAD in cycle 24.
- **Abort:**
  - abort=1 in cycle 10 gives IDLE in cycle 11: busy=0, round_en=0, round_idx=0, inv=0, and out_valid never asserts.
  - Separately, abort and out_ready both high in cycle 22 give IDLE in cycle 23.
- **Asynchronous reset:** rst pulsed mid-cycle 8.
  - All outputs reach reset values before the next clk edge.
  - After release, a new encrypt completes normally with out_valid in cycle 22 relative to its own start.
- **Parameter and ignore cases:**
  - NR=1: ROUND only in cycle 2 with round_idx=0, FINAL in cycle 3, out_valid in cycle 4.
  - start_valid held high through an operation starts no second LOAD until IDLE is reached.
